hwpe_stream_fifo_scm_ctrl: RTL

//   Stream-side controller that drives a latch-based SCM used as FIFO storage.
//   - Push stream in -> SCM write port; SCM read port -> pop stream out.
//   - Owns pointers, occupancy, flags and SCM timing rules.
//   - SCM timing rules: write data is sampled at the edge, then latched in the

---
 rtl/hwpe_stream_fifo_scm_ctrl_pkg.sv | 23 ++
 rtl/hwpe_stream_fifo_scm_ctrl_if.sv | 20 ++
 rtl/hwpe_stream_fifo_ctrl_ptr.sv | 45 ++++
 rtl/hwpe_stream_fifo_scm_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_fifo_scm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hwpe_stream_fifo_scm_ctrl_pkg
//   Shared types and helpers for the SCM-backed FIFO controller.
//   - flags_fifo_t : status bundle (empty, full, push_pointer, pop_pointer)
//   - occ_width()  : occupancy counter width for a given address width; one
//                    extra bit so that "completely full" (DEPTH) is representable
// ----------------------------------------------------------------------------
package hwpe_stream_fifo_scm_ctrl_pkg;

  localparam int unsigned FLAG_PTR_WIDTH = 8;

  typedef struct packed {
    logic                      empty;
    logic                      full;
    logic [FLAG_PTR_WIDTH-1:0] push_pointer;
    logic [FLAG_PTR_WIDTH-1:0] pop_pointer;
  } flags_fifo_t;

  function automatic int unsigned occ_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_stream_fifo_scm_ctrl_if.sv
// ----------------------------------------------------------------------------
// hwpe_stream_fifo_scm_ctrl_if
//   Valid/ready stream bundle used for both FIFO sides.
//   - data  : payload, DATA_WIDTH bits
//   - valid : producer has a word
//   - ready : consumer accepts the word
//   Modports: master (produces data/valid), slave (produces ready).
// ----------------------------------------------------------------------------
interface hwpe_stream_fifo_scm_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_ctrl_ptr.sv
// ----------------------------------------------------------------------------
// hwpe_stream_fifo_ctrl_ptr
//   Wrapping ADDR_WIDTH-bit address pointer (natural modulo 2**ADDR_WIDTH).
//   - clk, rst_n : clock, synchronous active-low reset
//   - clear_i    : synchronous flush to zero, higher priority than inc_i
//   - inc_i      : advance pointer by one
//   - ptr_o      : current pointer value
// ----------------------------------------------------------------------------
module hwpe_stream_fifo_ctrl_ptr #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Next pointer: flush, increment with natural wrap, or hold
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hwpe_stream_fifo_scm_ctrl.sv
// ----------------------------------------------------------------------------
// hwpe_stream_fifo_scm_ctrl
//   Controller driving a latch-based SCM used as FIFO storage. The SCM samples
//   write data at the edge and latches it in the following high phase; its
//   read address is registered and read data is combinational from it.
//   Ports:
//   - clk, rst_n        : clock, synchronous active-low reset
//   - clear_i           : synchronous flush (highest priority)
//   - push_i (slave)    : incoming stream -> SCM write port
//   - pop_o  (master)   : SCM read data -> outgoing stream (show-ahead)
//   - mem_we_o/waddr/wdata : SCM write port
//   - mem_re_o/raddr, mem_rdata_i : SCM read port
//   - flags_o           : empty, full, push_pointer, pop_pointer
//   Build option: define HWPE_STREAM_FIFO_SCM_CTRL_ASSERT_EN to compile in a
//   protocol checker; behaviour is identical either way.
// ----------------------------------------------------------------------------
module hwpe_stream_fifo_scm_ctrl
  import hwpe_stream_fifo_scm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  hwpe_stream_fifo_scm_ctrl_if.slave  push_i,
  hwpe_stream_fifo_scm_ctrl_if.master pop_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_waddr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  output logic                   mem_re_o,
  output logic [ADDR_WIDTH-1:0]  mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  output flags_fifo_t            flags_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned OCC_W = occ_width(ADDR_WIDTH);

  logic [OCC_W-1:0]      occ_q, occ_d, avail_s;
  logic                  out_valid_q, out_valid_d;
  logic                  active_s, full_s;
  logic                  push_ready_s, push_fire_s;
  logic                  pop_valid_s, pop_fire_s, mem_re_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_s, rd_ptr_s, pop_addr_s;

  // Handshakes, read request and next state; reset and clear mask all activity
  always_comb begin
    active_s     = rst_n & ~clear_i;
    full_s       = (occ_q == OCC_W'(DEPTH));
    push_ready_s = active_s & ~full_s;
    push_fire_s  = push_i.valid & push_ready_s;
    pop_valid_s  = active_s & out_valid_q;
    pop_fire_s   = pop_valid_s & pop_o.ready;
    // Words in storage not yet under the output register. A word written in
    // cycle T enters occupancy at the end of T, so it is requestable from T+1,
    // when the SCM latch has already captured it.
    avail_s      = occ_q - OCC_W'(out_valid_q);
    mem_re_s     = active_s & (avail_s != '0) & (~out_valid_q | pop_fire_s);

    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      occ_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      occ_d = occ_q + OCC_W'(push_fire_s) - OCC_W'(pop_fire_s);
      if (mem_re_s) begin
        out_valid_d = 1'b1;
      end else if (pop_fire_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Occupancy and output-valid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
    end
  end

  hwpe_stream_fifo_ctrl_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) i_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .inc_i   (push_fire_s),
    .ptr_o   (wr_ptr_s)
  );

  hwpe_stream_fifo_ctrl_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) i_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .inc_i   (mem_re_s),
    .ptr_o   (rd_ptr_s)
  );

  // rd_ptr runs one ahead of the word presented while out_valid is set
  assign pop_addr_s = rd_ptr_s - ADDR_WIDTH'(out_valid_q);

  assign push_i.ready = push_ready_s;
  assign pop_o.valid  = pop_valid_s;
  assign pop_o.data   = mem_rdata_i;
  assign mem_we_o     = push_fire_s;
  assign mem_waddr_o  = wr_ptr_s;
  assign mem_wdata_o  = push_i.data;
  assign mem_re_o     = mem_re_s;
  assign mem_raddr_o  = rd_ptr_s;

  assign flags_o.empty        = ~rst_n | (occ_q == '0);
  assign flags_o.full         = rst_n & full_s;
  assign flags_o.push_pointer = FLAG_PTR_WIDTH'(wr_ptr_s);
  assign flags_o.pop_pointer  = FLAG_PTR_WIDTH'(pop_addr_s);

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_ASSERT_EN
  hwpe_stream_fifo_scm_ctrl_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OCC_W      (OCC_W)
  ) i_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .push_fire_i (push_fire_s),
    .full_i      (full_s),
    .mem_we_i    (push_fire_s),
    .mem_waddr_i (wr_ptr_s),
    .mem_re_i    (mem_re_s),
    .mem_raddr_i (rd_ptr_s),
    .pop_valid_i (pop_valid_s),
    .pop_ready_i (pop_o.ready),
    .pop_data_i  (mem_rdata_i),
    .occ_i       (occ_q)
  );
`endif

endmodule

`ifdef HWPE_STREAM_FIFO_SCM_CTRL_ASSERT_EN
// Protocol checker for the FIFO controller
module hwpe_stream_fifo_scm_ctrl_chk #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OCC_W      = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear_i,
  input logic                  push_fire_i,
  input logic                  full_i,
  input logic                  mem_we_i,
  input logic [ADDR_WIDTH-1:0] mem_waddr_i,
  input logic                  mem_re_i,
  input logic [ADDR_WIDTH-1:0] mem_raddr_i,
  input logic                  pop_valid_i,
  input logic                  pop_ready_i,
  input logic [DATA_WIDTH-1:0] pop_data_i,
  input logic [OCC_W-1:0]      occ_i
);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_fire_i && full_i));
  a_no_raw_same_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_re_i && mem_we_i && (mem_raddr_i == mem_waddr_i)));
  a_pop_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_valid_i && !pop_ready_i && !clear_i) |=> (clear_i || $stable(pop_data_i)));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_i <= OCC_W'(2 ** ADDR_WIDTH));
endmodule
`endif
